// File: rtl/frogger_game_ctrl.sv
// Game sequencer for the 16x16 Frogger display: lives, level, lane scroll
// rate and crash-detector clear, driven by a single phase state machine.
module frogger_game_ctrl #(
  parameter int NLIVES    = 3,
  parameter int NLEVELS   = 4,
  parameter int TICK_BASE = 1024,
  parameter int FLASH_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       crash,
  input  logic       goal,
  output logic       crash_clr,
  output logic       frog_home,
  output logic       lane_tick,
  output logic       flash,
  output logic [1:0] lives,
  output logic [1:0] level,
  output logic [2:0] state
);

  localparam int CW = $clog2(TICK_BASE);
  localparam int FW = (FLASH_LEN > 1) ? $clog2(FLASH_LEN) : 1;
  localparam logic [1:0]    LIVES_INIT = 2'(NLIVES);
  localparam logic [1:0]    LAST_LEVEL = 2'(NLEVELS - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESPAWN = 3'd1,
    S_PLAY    = 3'd2,
    S_HIT     = 3'd3,
    S_LEVELUP = 3'd4,
    S_OVER    = 3'd5,
    S_WIN     = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [1:0]    level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d, tick_max_s;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          crash_clr_q, crash_clr_d;
  logic          frog_home_q, frog_home_d;
  logic          lane_tick_q, lane_tick_d;
  logic          flash_q, flash_d;

  // Next-state, lives and level update
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    case (state_q)
      S_IDLE, S_OVER, S_WIN: begin
        if (start) begin
          state_d = S_RESPAWN;
          lives_d = LIVES_INIT;
          level_d = 2'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_RESPAWN: state_d = S_PLAY;
      S_PLAY: begin
        // crash outranks goal, so a simultaneous goal leaves level untouched
        if (crash) begin
          state_d = S_HIT;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        end else if (goal) begin
          if (level_q == LAST_LEVEL) begin
            state_d = S_WIN;
          end else begin
            state_d = S_LEVELUP;
            level_d = level_q + 2'd1;
          end
        end else begin
          state_d = S_PLAY;
        end
      end
      S_HIT: begin
        if (flash_cnt_q == FLASH_LAST) begin
          state_d = (lives_q == 2'd0) ? S_OVER : S_RESPAWN;
        end else begin
          state_d = S_HIT;
        end
      end
      S_LEVELUP: state_d = S_RESPAWN;
      default:   state_d = S_IDLE;
    endcase
  end

  // Tick and flash counters plus output decode from the next state, so every
  // output comes straight off a flop
  always_comb begin
    tick_max_s = CW'((TICK_BASE >> level_d) - 1);
    if (state_q == S_PLAY && state_d == S_PLAY) begin
      cnt_d = (cnt_q == tick_max_s) ? '0 : cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
    if (state_q == S_HIT && state_d == S_HIT) begin
      flash_cnt_d = flash_cnt_q + FW'(1);
    end else begin
      flash_cnt_d = '0;
    end
    flash_d     = (state_d == S_HIT);
    frog_home_d = (state_d == S_RESPAWN);
    crash_clr_d = !(state_d == S_PLAY || state_d == S_HIT);
    lane_tick_d = (state_d == S_PLAY) && (cnt_d == tick_max_s);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lives_q     <= LIVES_INIT;
      level_q     <= 2'd0;
      cnt_q       <= '0;
      flash_cnt_q <= '0;
      crash_clr_q <= 1'b1;
      frog_home_q <= 1'b0;
      lane_tick_q <= 1'b0;
      flash_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      flash_cnt_q <= flash_cnt_d;
      crash_clr_q <= crash_clr_d;
      frog_home_q <= frog_home_d;
      lane_tick_q <= lane_tick_d;
      flash_q     <= flash_d;
    end
  end

  assign state     = state_q;
  assign lives     = lives_q;
  assign level     = level_q;
  assign crash_clr = crash_clr_q;
  assign frog_home = frog_home_q;
  assign lane_tick = lane_tick_q;
  assign flash     = flash_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Table-driven bench for frogger_game_ctrl with an expected-value queue;
// TICK_BASE=16, FLASH_LEN=4.
module tb_frogger_game_ctrl;

  logic       clk, reset, start, crash, goal;
  logic       crash_clr, frog_home, lane_tick, flash;
  logic [1:0] lives, level;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       start;
    logic       crash;
    logic       goal;
    logic [2:0] st;
    logic [1:0] lv;
    logic [1:0] lvl;
    logic       fl;
    logic       fh;
    logic       lt;
    logic       cc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  frogger_game_ctrl #(
    .NLIVES(3), .NLEVELS(4), .TICK_BASE(16), .FLASH_LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .crash(crash), .goal(goal),
    .crash_clr(crash_clr), .frog_home(frog_home), .lane_tick(lane_tick),
    .flash(flash), .lives(lives), .level(level), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, c, g, input logic [2:0] st,
                              input logic [1:0] lv, lvl,
                              input logic fl, fh, lt, cc);
    vec_t v;
    v = '{s, c, g, st, lv, lvl, fl, fh, lt, cc};
    return v;
  endfunction

  function automatic void add(input logic s, c, g, input logic [2:0] st,
                              input logic [1:0] lv, lvl,
                              input logic fl, fh, lt, cc);
    vecs.push_back(mk(s, c, g, st, lv, lvl, fl, fh, lt, cc));
  endfunction

  // n idle PLAY cycles starting at PLAY entry; tick every p cycles
  function automatic void add_play(input int n, input int p,
                                   input logic [1:0] lv, lvl);
    for (int k = 1; k <= n; k++)
      add(1'b0, 1'b0, 1'b0, 3'd2, lv, lvl, 1'b0, 1'b0, (k % p) == 0, 1'b0);
  endfunction

  function automatic void add_hit3(input logic [1:0] lv, lvl);
    for (int k = 0; k < 3; k++)
      add(1'b0, 1'b0, 1'b0, 3'd3, lv, lvl, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic compare(input string tag, input int idx);
    vec_t e;
    e = exp_q.pop_front();
    n_checks++;
    if ({state, lives, level, flash, frog_home, lane_tick, crash_clr} !==
        {e.st, e.lv, e.lvl, e.fl, e.fh, e.lt, e.cc}) begin
      n_fail++;
      $display("FAIL %s #%0d: got st=%0d lives=%0d lvl=%0d fl/fh/lt/cc=%b%b%b%b, want st=%0d lives=%0d lvl=%0d fl/fh/lt/cc=%b%b%b%b",
               tag, idx, state, lives, level, flash, frog_home, lane_tick, crash_clr,
               e.st, e.lv, e.lvl, e.fl, e.fh, e.lt, e.cc);
    end
  endtask

  task automatic apply(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    start = v.start;
    crash = v.crash;
    goal  = v.goal;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    crash = 1'b0;
    goal  = 1'b0;
    compare(tag, idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // start -> RESPAWN -> 40 PLAY cycles at P=16
    add(1, 0, 0, 3'd1, 2'd3, 2'd0, 0, 1, 0, 1);
    add_play(40, 16, 2'd3, 2'd0);
    add(0, 0, 1, 3'd4, 2'd3, 2'd1, 0, 0, 0, 1);
    add(1, 0, 0, 3'd1, 2'd3, 2'd1, 0, 1, 0, 1);   // start in LEVELUP ignored
    add_play(16, 8, 2'd3, 2'd1);
    // crash while the tick is showing
    add(0, 1, 0, 3'd3, 2'd2, 2'd1, 1, 0, 0, 0);
    add(1, 0, 0, 3'd3, 2'd2, 2'd1, 1, 0, 0, 0);   // start in HIT ignored
    add(0, 1, 1, 3'd3, 2'd2, 2'd1, 1, 0, 0, 0);   // crash/goal in HIT ignored
    add(0, 0, 0, 3'd3, 2'd2, 2'd1, 1, 0, 0, 0);
    add(0, 0, 0, 3'd1, 2'd2, 2'd1, 0, 1, 0, 1);
    add(1, 0, 0, 3'd2, 2'd2, 2'd1, 0, 0, 0, 0);   // start in RESPAWN ignored
    add(1, 0, 0, 3'd2, 2'd2, 2'd1, 0, 0, 0, 0);   // start in PLAY ignored
    add(0, 1, 1, 3'd3, 2'd1, 2'd1, 1, 0, 0, 0);   // crash beats goal
    add_hit3(2'd1, 2'd1);
    add(0, 0, 0, 3'd1, 2'd1, 2'd1, 0, 1, 0, 1);
    add(0, 0, 0, 3'd2, 2'd1, 2'd1, 0, 0, 0, 0);
    add(0, 1, 0, 3'd3, 2'd0, 2'd1, 1, 0, 0, 0);
    add_hit3(2'd0, 2'd1);
    add(0, 0, 0, 3'd5, 2'd0, 2'd1, 0, 0, 0, 1);   // OVER
    add(0, 1, 1, 3'd5, 2'd0, 2'd1, 0, 0, 0, 1);
    add(0, 0, 0, 3'd5, 2'd0, 2'd1, 0, 0, 0, 1);
    add(1, 0, 0, 3'd1, 2'd3, 2'd0, 0, 1, 0, 1);
    add_play(1, 16, 2'd3, 2'd0);
    // climb to the last level and win
    add(0, 0, 1, 3'd4, 2'd3, 2'd1, 0, 0, 0, 1);
    add(0, 0, 0, 3'd1, 2'd3, 2'd1, 0, 1, 0, 1);
    add_play(1, 8, 2'd3, 2'd1);
    add(0, 0, 1, 3'd4, 2'd3, 2'd2, 0, 0, 0, 1);
    add(0, 0, 0, 3'd1, 2'd3, 2'd2, 0, 1, 0, 1);
    add_play(8, 4, 2'd3, 2'd2);
    add(0, 0, 1, 3'd4, 2'd3, 2'd3, 0, 0, 0, 1);
    add(0, 0, 0, 3'd1, 2'd3, 2'd3, 0, 1, 0, 1);
    add_play(4, 2, 2'd3, 2'd3);
    add(0, 0, 1, 3'd6, 2'd3, 2'd3, 0, 0, 0, 1);   // WIN
    add(0, 1, 0, 3'd6, 2'd3, 2'd3, 0, 0, 0, 1);
    add(0, 0, 1, 3'd6, 2'd3, 2'd3, 0, 0, 0, 1);
    add(1, 0, 0, 3'd1, 2'd3, 2'd0, 0, 1, 0, 1);
    add_play(2, 16, 2'd3, 2'd0);
    add(0, 1, 0, 3'd3, 2'd2, 2'd0, 1, 0, 0, 0);
    add(0, 0, 0, 3'd3, 2'd2, 2'd0, 1, 0, 0, 0);

    start = 1'b0;
    crash = 1'b0;
    goal  = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 3'd0, 2'd3, 2'd0, 0, 0, 0, 1));
    compare("reset_state", 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], "table", i);

    // reset between edges in the middle of HIT
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 3'd0, 2'd3, 2'd0, 0, 0, 0, 1));
    compare("async_reset_mid_hit", 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, 1, 3'd0, 2'd3, 2'd0, 0, 0, 0, 1), "idle_after_reset", i);
    apply(mk(1, 0, 0, 3'd1, 2'd3, 2'd0, 0, 1, 0, 1), "start_after_reset", 0);
    apply(mk(0, 0, 0, 3'd2, 2'd3, 2'd0, 0, 0, 0, 0), "play_after_reset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frogger_game_ctrl.md
# frogger_game_ctrl

Game sequencer for the 16x16 Frogger display. Sits between the player start key, the crash detector and goal logic, and the lane/frog datapath. Owns lives, level, lane scroll rate and the crash detector's clear. Drives a single state machine through start, respawn, play, hit, level-up and end-of-game phases.

## Interface
- NLIVES, 3: lives granted per game; legal 1..3
- NLEVELS, 4: number of levels; legal 1..4
- TICK_BASE, 1024: lane_tick period at level 0, in clk cycles; power of two, >= 16
- FLASH_LEN, 8: cycles spent in HIT; >= 1

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; low forces reset values immediately
- start  in  1  one-cycle start/restart pulse, already synchronized and debounced
- crash  in  1  level from the crash detector; high = frog overlaps traffic
- goal  in  1  level; high = frog occupies the top row
- crash_clr  out  1  held high to clear the crash detector (its sync active-high reset)
- frog_home  out  1  one-cycle pulse; returns the frog to its start cell
- lane_tick  out  1  one-cycle pulse; advances traffic lanes one column
- flash  out  1  high while in HIT; display flashes the frog
- lives  out  2  remaining lives
- level  out  2  current level, 0-based
- state  out  3  state encoding for debug/display

## Operation
- States and encoding: IDLE=0, RESPAWN=1, PLAY=2, HIT=3, LEVELUP=4, OVER=5, WIN=6.
- Reset values: state=IDLE, lives=NLIVES, level=0, flash=0, frog_home=0, lane_tick=0, crash_clr=1, tick and flash counters 0.
- IDLE: start -> RESPAWN; lives<=NLIVES, level<=0.
- RESPAWN: exactly 1 cycle; frog_home=1; -> PLAY.
- PLAY, evaluated in priority order:
  - crash -> HIT; lives<=lives-1 on the same edge.
  - goal with level==NLEVELS-1 -> WIN.
  - goal otherwise -> LEVELUP; level<=level+1.
  - start is ignored.
- HIT: flash=1; stays exactly FLASH_LEN cycles. On exit: lives==0 -> OVER, else -> RESPAWN. crash and goal are ignored.
- LEVELUP: exactly 1 cycle -> RESPAWN.
- OVER, WIN: hold until start. On start -> RESPAWN; lives<=NLIVES, level<=0.
- start in RESPAWN, HIT or LEVELUP is ignored.
- crash_clr = 1 in IDLE, RESPAWN, LEVELUP, OVER and WIN; 0 in PLAY and HIT. In HIT the detector therefore stays latched until the next clear.
- Tick divider:
  - period P = TICK_BASE >> level.
  - Counter runs only in PLAY, counting 0..P-1 and wrapping. It is forced to 0 in every other state.
  - lane_tick = (state==PLAY && cnt==P-1).
- All outputs are decoded from registers only; no combinational path from any input to any output.
- lives never decrements below 0. The lives==0 check uses the post-decrement value.

## Timing
- crash high at edge n while in PLAY: state=HIT and lives decremented after edge n. flash is high cycles n..n+FLASH_LEN-1. RESPAWN or OVER follows after edge n+FLASH_LEN.
- goal to next PLAY: LEVELUP 1 cycle, RESPAWN 1 cycle, PLAY on the 3rd cycle after the goal edge.
- First lane_tick occurs in the P-th cycle of PLAY (P-1 cycles after PLAY entry). Subsequent ticks repeat every P cycles.
- A new level's P takes effect at the next PLAY entry; the counter is already 0.
- crash and lane_tick in the same cycle: the tick is still emitted, and the transition to HIT happens at that edge.
- crash and goal in the same cycle: crash wins; level is unchanged.
- Reset asserted mid-game: all registers return to reset values asynchronously. Deassertion is taken synchronously at the next edge, in IDLE.

## Test plan
Bench parameters: TICK_BASE=16, FLASH_LEN=4, defaults otherwise.
- Reset, then start pulse -> state 1 for 1 cycle with frog_home=1, then state 2; crash_clr falls to 0 on PLAY entry; lives=3, level=0.
- Hold PLAY for 40 cycles with no events -> lane_tick pulses at PLAY cycles 16 and 32 only. After one goal, the next PLAY ticks every 8 cycles.
- Assert crash in PLAY -> HIT with flash high exactly 4 cycles, lives 3->2, then RESPAWN with crash_clr=1, then PLAY. Repeat twice -> lives=0 and state=5 (OVER), held until start.
- Assert goal 4 times, returning to PLAY each time -> level 0->1->2->3, then WIN (state=6). start from WIN -> lives=3, level=0, RESPAWN.
- Assert crash and goal in the same PLAY cycle -> HIT, level unchanged. start during HIT -> ignored.
- Drop reset low mid-HIT, between clock edges -> outputs reach reset values immediately (state=0, flash=0, crash_clr=1). Release reset -> stays in IDLE until start.
